// File: rtl/unified_mem_arbiter_if.sv
// Bundle of core-side request/response and memory-side bus signals.
// master: arbiter view; slave: core + memory view (testbench side).
interface unified_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        grant_d;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        input  mem_ready, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_be, grant_d
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
        output mem_ready, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be, grant_d
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and data ports onto one single-ported memory.
// Ports: clk, clr (sync active-low), bus (master modport: fetch/data
// requests, rdata/ready responses, mem_* bus, grant_d debug).
// Optional ARB_TIMEOUT_EN: watchdog aborts stuck accesses with
// rdata 32'hDEADBEEF and sets sticky bus_err output.
module unified_mem_arbiter #(
    parameter int MAX_D_STREAK = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic clk,
    input  logic clr,
    unified_mem_arbiter_if.master bus
`ifdef ARB_TIMEOUT_EN
    ,
    output logic bus_err
`endif
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] MAXS = SW'(MAX_D_STREAK);

    state_e        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          if_ready_q, if_ready_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          d_ready_q, d_ready_d;
    logic          grant_d_q, grant_d_d;
`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          bus_err_q, bus_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        if_ready_d  = 1'b0;
        d_rdata_d   = d_rdata_q;
        d_ready_d   = 1'b0;
        grant_d_d   = grant_d_q;
`ifdef ARB_TIMEOUT_EN
        tmo_d       = tmo_q;
        bus_err_d   = bus_err_q;
`endif
        unique case (state_q)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                tmo_d = '0;
`endif
                // Data wins unless fetch has waited out a full streak.
                if (bus.d_req && (!bus.if_req || streak_q < MAXS)) begin
                    state_d     = BUSY_D;
                    mem_valid_d = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_be_d    = bus.d_be;
                    grant_d_d   = 1'b1;
                    if (!bus.if_req)
                        streak_d = '0;
                    else if (streak_q != MAXS)
                        streak_d = streak_q + SW'(1);
                end else if (bus.if_req) begin
                    state_d     = BUSY_I;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                    grant_d_d   = 1'b0;
                    streak_d    = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = bus.mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = mem_we_q ? 32'h0 : bus.mem_rdata;
                        d_ready_d = 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_q == TLAST) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    bus_err_d   = 1'b1;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = 32'hDEADBEEF;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = 32'hDEADBEEF;
                        d_ready_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            d_rdata_q   <= '0;
            d_ready_q   <= 1'b0;
            grant_d_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            d_rdata_q   <= d_rdata_d;
            d_ready_q   <= d_ready_d;
            grant_d_q   <= grant_d_d;
`ifdef ARB_TIMEOUT_EN
            tmo_q       <= tmo_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.grant_d   = grant_d_q;
`ifdef ARB_TIMEOUT_EN
    assign bus_err       = bus_err_q;
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: requester and memory
// models run in one cycle task; expected results queued at issue.
module tb_unified_mem_arbiter;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
`ifdef ARB_TIMEOUT_EN
    logic bus_err;
`endif

    unified_mem_arbiter_if bus ();

    unified_mem_arbiter #(
        .MAX_D_STREAK(4)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
`ifdef ARB_TIMEOUT_EN
        ,
        .bus_err(bus_err)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    txn_t exp_i[$];
    txn_t exp_d[$];
    bit   exp_g[$];
    bit   prev_v = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic [4:0]  h_ctl;
    int rise_cyc = 0, mr_cyc = 0, ir_cyc = 0, dr_cyc = 0;
    int lat = 0, wcnt = 0;
    bit hang = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd_func(input logic [31:0] a);
        return (a == 32'h100) ? 32'h00500093 : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic tick();
        txn_t t;
        bit   g;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.if_ready) begin
            ir_cyc = cyc;
            chk("if_excl", bus.d_ready, 0);
            chk("if_mv_low", bus.mem_valid, 0);
            if (exp_i.size() == 0) chk("if_spurious", 1, 0);
            else begin
                t = exp_i.pop_front();
                chk("if_rdata", bus.if_rdata, t.rdata);
            end
            bus.if_req = 1'b0;
        end
        if (bus.d_ready) begin
            dr_cyc = cyc;
            chk("d_mv_low", bus.mem_valid, 0);
            if (exp_d.size() == 0) chk("d_spurious", 1, 0);
            else begin
                t = exp_d.pop_front();
                chk("d_rdata", bus.d_rdata, t.rdata);
            end
            bus.d_req = 1'b0;
        end
        if (bus.mem_valid && !prev_v) begin
            rise_cyc = cyc;
            if (exp_g.size() == 0) chk("grant_spurious", 1, 0);
            else begin
                g = exp_g.pop_front();
                chk("grant_d", bus.grant_d, g);
                if ((g && exp_d.size() == 0) || (!g && exp_i.size() == 0))
                    chk("grant_noexp", 1, 0);
                else begin
                    t = g ? exp_d[0] : exp_i[0];
                    chk("mem_aw", {bus.mem_addr, bus.mem_wdata},
                        {t.addr, t.wdata});
                    chk("mem_ctl", {bus.mem_we, bus.mem_be}, {t.we, t.be});
                end
            end
            h_addr  = bus.mem_addr;
            h_wdata = bus.mem_wdata;
            h_ctl   = {bus.mem_we, bus.mem_be};
        end else if (bus.mem_valid) begin
            chk("hold_aw", {bus.mem_addr, bus.mem_wdata}, {h_addr, h_wdata});
            chk("hold_ctl", {bus.mem_we, bus.mem_be}, h_ctl);
        end
        prev_v = bus.mem_valid;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        if (bus.mem_valid && !hang) begin
            if (wcnt == lat) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rd_func(bus.mem_addr);
                mr_cyc = cyc;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    endtask

    task automatic req_i(input logic [31:0] a, input bit to);
        txn_t t;
        t.we = 1'b0; t.addr = a; t.wdata = '0; t.be = 4'hF;
        t.rdata = to ? 32'hDEADBEEF : rd_func(a);
        exp_i.push_back(t);
        bus.if_req = 1'b1;
        bus.if_addr = a;
    endtask

    task automatic req_d(input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = wd; t.be = be;
        t.rdata = we ? 32'h0 : rd_func(a);
        exp_d.push_back(t);
        bus.d_req = 1'b1;
        bus.d_we = we;
        bus.d_addr = a;
        bus.d_wdata = wd;
        bus.d_be = be;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max && (bus.if_req || bus.d_req); i++) tick();
        if (bus.if_req || bus.d_req) begin
            chk("wait_timeout", 1, 0);
            bus.if_req = 1'b0;
            bus.d_req = 1'b0;
        end
        tick();
        tick();
    endtask

    int t0;

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
        clr = 1'b0;
        tick();
        tick();
        chk("rst_mv", bus.mem_valid, 0);
        chk("rst_rdy", {bus.if_ready, bus.d_ready}, 0);
        chk("rst_gd", bus.grant_d, 0);
        chk("rst_aw", {bus.mem_addr, bus.mem_wdata}, 0);
        chk("rst_ctl", {bus.mem_we, bus.mem_be}, 0);
        chk("rst_rd", {bus.if_rdata, bus.d_rdata}, 0);
`ifdef ARB_TIMEOUT_EN
        chk("rst_berr", bus_err, 0);
`endif
        clr = 1'b1;
        tick();

        // fetch only, memory answers after 2 wait cycles
        lat = 2;
        exp_g.push_back(0);
        t0 = cyc;
        req_i(32'h100, 0);
        wait_idle(50);
        chk("f_rise", rise_cyc - t0, 1);
        chk("f_ready", ir_cyc - t0, 4);
        chk("f_mr_lat", ir_cyc - mr_cyc, 1);
        chk("f_hold", bus.if_rdata, 32'h00500093);

        // simultaneous: data first
        lat = 1;
        exp_g.push_back(1);
        exp_g.push_back(0);
        req_i(32'h200, 0);
        req_d(0, 32'h2000, 0, 4'hF);
        wait_idle(50);
        chk("sim_order", ir_cyc > dr_cyc, 1);
        chk("sim_gd_last", bus.grant_d, 0);

        // starvation guard
        lat = 0;
        for (int n = 0; n < 4; n++) exp_g.push_back(1);
        exp_g.push_back(0);
        exp_g.push_back(1);
        req_i(32'h400, 0);
        for (int n = 0; n < 5; n++) begin
            req_d(0, 32'h2100 + 32'(4 * n), 0, 4'hF);
            for (int i = 0; i < 50 && bus.d_req; i++) tick();
            if (bus.d_req) begin
                chk("starve_timeout", 1, 0);
                bus.d_req = 1'b0;
            end
        end
        wait_idle(50);
        exp_g.push_back(1);
        exp_g.push_back(0);
        req_i(32'h500, 0);
        req_d(0, 32'h2200, 0, 4'hF);
        wait_idle(50);

        // store with 5 stall cycles
        lat = 5;
        exp_g.push_back(1);
        req_d(1, 32'h3004, 32'hCAFEF00D, 4'b0011);
        wait_idle(50);
        chk("st_stall", mr_cyc - rise_cyc, 5);
        chk("st_rdata_hold", bus.d_rdata, 0);
        chk("st_gd", bus.grant_d, 1);

        // reset during a stuck data access
        hang = 1'b1;
        exp_g.push_back(1);
        req_d(0, 32'h2400, 0, 4'hF);
        tick(); tick(); tick();
        chk("rb_busy", bus.mem_valid, 1);
        clr = 1'b0;
        tick();
        clr = 1'b1;
        bus.d_req = 1'b0;
        exp_d.delete();
        chk("rb_mv", bus.mem_valid, 0);
        chk("rb_rdy", {bus.if_ready, bus.d_ready}, 0);
        chk("rb_gd", bus.grant_d, 0);
        hang = 1'b0;
        lat = 0;
        tick(); tick(); tick();
        chk("rb_quiet", {bus.mem_valid, bus.if_ready, bus.d_ready}, 0);
        exp_g.push_back(0);
        t0 = cyc;
        req_i(32'h600, 0);
        wait_idle(50);
        chk("rb_idle_rise", rise_cyc - t0, 1);

`ifdef ARB_TIMEOUT_EN
        // watchdog abort on a fetch
        hang = 1'b1;
        exp_g.push_back(0);
        t0 = cyc;
        req_i(32'h700, 1);
        wait_idle(50);
        chk("to_lat", ir_cyc - t0, 9);
        chk("to_berr", bus_err, 1);
        hang = 1'b0;
        exp_g.push_back(1);
        req_d(0, 32'h2800, 0, 4'hF);
        wait_idle(50);
        chk("to_sticky", bus_err, 1);
        clr = 1'b0;
        tick();
        clr = 1'b1;
        chk("to_clr", bus_err, 0);
`endif

        chk("sb_empty", {exp_i.size() == 0, exp_d.size() == 0,
                         exp_g.size() == 0}, 3'b111);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
